imm_extend_ctrl: RTL and testbench
==================================

Name: imm_extend_ctrl

Overview:
Decode-stage controller for immediate generation. It accepts fetched instructions over a valid/ready handshake and selects the extension mode per opcode: sign, zero, LUI, branch-offset or jump-target. It buffers the 32-bit immediate and its kind in a 2-entry FIFO and presents them to the ID/EX register under backpressure.
It sits between the IF/ID register and the ALU-source / branch-target muxes.

Parameters:
DEPTH, 2, FIFO entries (fixed at 2; the count width is 2 bits).
CNT_W, 16, width of the wrapping accepted-instruction counter.

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Instr_In  input  32  instruction word; opcode [31:26], imm [15:0], target [25:0]
In_Valid  input  1  Instr_In is valid this cycle
In_Ready  output  1  block can accept an instruction (high when count<2)
Flush  input  1  synchronous pipeline flush (branch taken)
Imm_Out  output  32  extended immediate at FIFO head
Imm_Kind  output  3  0 NONE, 1 SEXT, 2 ZEXT, 3 LUI, 4 BRANCH, 5 JUMP
Out_Valid  output  1  head entry valid (count!=0)
Out_Ready  input  1  consumer takes the head this cycle
Accept_Cnt  output  CNT_W  number of accepted instructions, wraps at 2^CNT_W

Behaviour:
- Reset (Rst_n low, asynchronous): count=0; both entries=0; Accept_Cnt=0.
  - Resulting outputs: Out_Valid=0, Imm_Out=0, Imm_Kind=0, In_Ready=1.
  - Reset mid-operation discards all buffered entries.
- push = In_Valid & In_Ready; pop = Out_Valid & Out_Ready. Both are evaluated at the rising edge.
- Latency: an instruction accepted at edge N into an empty FIFO gives Out_Valid=1 and its Imm_Out/Imm_Kind after edge N.
  - There is no combinational path from Instr_In to Imm_Out.
- Decode is combinational and is registered on push:
  - SEXT, opcodes 08-0B, 20, 21, 23, 24, 25, 28, 29, 2B (hex): {{16{imm[15]}}, imm}.
  - ZEXT, opcodes 0C, 0D, 0E: {16'h0000, imm}.
  - LUI, opcode 0F: {imm, 16'h0000}.
  - BRANCH, opcodes 01, 04-07: {{14{imm[15]}}, imm, 2'b00}.
  - JUMP, opcodes 02, 03: {4'h0, target, 2'b00}. The PC logic merges PC[31:28].
  - All other opcodes, including 00 (R-type): kind NONE, Imm_Out value 0.
- FIFO: strict in-order delivery; head is the oldest entry; Imm_Out/Imm_Kind are driven from the head register.
  - count update: push only → +1; pop only → −1; push & pop → unchanged (head advances, tail written).
  - Full (count=2): In_Ready=0, so no push. A pop at full raises In_Ready only in the following cycle (no combinational ready-through).
  - Empty (count=0): Out_Valid=0 and Imm_Out/Imm_Kind are held at the last values. Out_Ready is ignored.
- Flush: at the edge, count←0 and the pointers reset.
  - Flush has priority over a simultaneous push and pop; neither takes effect and Accept_Cnt does not increment.
  - Entry data is not cleared.
- Accept_Cnt increments by 1 on every push and wraps from 2^CNT_W−1 to 0.
- Out_Valid must not drop while count!=0 unless Flush or reset occurs.

Decomposition:
- Shared package imm_ctrl_pkg holds:
  - Imm_Kind encodings: KIND_NONE through KIND_JUMP.
  - Opcode constants: OP_ADDI, OP_ANDI, OP_LUI, OP_BEQ, OP_J, etc.
- One sub-module, imm_ext_decode: purely combinational, Instr_In → {Imm_Out, Imm_Kind}.
- The FIFO, pointers, count and counter live in imm_extend_ctrl.

Test Plan:
1. Decode sweep, Out_Ready=1:
   - 0x2008FFFF → Imm_Out 0xFFFFFFFF, kind 1.
   - 0x3508FFFF → 0x0000FFFF, kind 2.
   - 0x3C011234 → 0x12340000, kind 3.
   - 0x1000FFFE → 0xFFFFFFF8, kind 4.
   - 0x08000010 → 0x00000040, kind 5.
   - 0x012A4020 → 0x00000000, kind 0.
   - Each result appears one cycle after acceptance.
2. Backpressure: Out_Ready=0, push 0x20080005, 0x20080006, 0x20080007 back-to-back.
   - In_Ready drops after the 2nd push; the 3rd is held.
   - Raise Out_Ready → outputs 5, 6, 7 in order; Accept_Cnt ends at 3.
3. Simultaneous push/pop at count=1, continuous streaming of 10 instructions with Out_Ready=1.
   - count stays 1; no bubbles after the first; Accept_Cnt=10.
4. Flush with count=2 plus a concurrent push of 0x3C01ABCD.
   - Next cycle Out_Valid=0, In_Ready=1; the LUI is not delivered; Accept_Cnt is unchanged.
5. Assert Rst_n low mid-stream, asynchronously between edges, with count=2.
   - Out_Valid=0, Imm_Out=0 and Accept_Cnt=0 immediately, without waiting for a clock edge.
   - After release, the first push behaves as in scenario 1.
6. Counter wrap with CNT_W=4: 17 pushes → Accept_Cnt reads 1.

Source files
------------

// File: rtl/imm_ctrl_pkg.sv
// Shared encodings for immediate-extension decode: kind codes, opcodes, FIFO entry layout.
package imm_ctrl_pkg;

  localparam int DEPTH = 2;

  typedef enum logic [2:0] {
    KIND_NONE   = 3'd0,
    KIND_SEXT   = 3'd1,
    KIND_ZEXT   = 3'd2,
    KIND_LUI    = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_JUMP   = 3'd5
  } imm_kind_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef struct packed {
    logic [31:0] imm;
    imm_kind_e   kind;
  } imm_ent_t;

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational opcode decode to extended immediate and kind; zero latency, no flow control.
module imm_ext_decode
  import imm_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output imm_ent_t    o_ent
);

  logic [5:0]  w_op;
  logic [15:0] w_imm16;
  logic [25:0] w_target;

  assign w_op     = i_instr[31:26];
  assign w_imm16  = i_instr[15:0];
  assign w_target = i_instr[25:0];

  always_comb begin
    o_ent.imm  = 32'h0000_0000;
    o_ent.kind = KIND_NONE;
    case (w_op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: begin
        o_ent.imm  = {{16{w_imm16[15]}}, w_imm16};
        o_ent.kind = KIND_SEXT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_ent.imm  = {16'h0000, w_imm16};
        o_ent.kind = KIND_ZEXT;
      end
      OP_LUI: begin
        o_ent.imm  = {w_imm16, 16'h0000};
        o_ent.kind = KIND_LUI;
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        o_ent.imm  = {{14{w_imm16[15]}}, w_imm16, 2'b00};
        o_ent.kind = KIND_BRANCH;
      end
      // Upper PC bits are merged downstream by the PC logic.
      OP_J, OP_JAL: begin
        o_ent.imm  = {4'h0, w_target, 2'b00};
        o_ent.kind = KIND_JUMP;
      end
      default: begin
        o_ent.imm  = 32'h0000_0000;
        o_ent.kind = KIND_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_ctrl.sv
// Decode-stage immediate generator with a 2-entry in-order FIFO; result one cycle after accept.
// In_Ready depends only on the registered count (no ready-through); Flush clears occupancy.
module imm_extend_ctrl
  import imm_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      Instr_In,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Flush,
  output logic [31:0]      Imm_Out,
  output logic [2:0]       Imm_Kind,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [CNT_W-1:0] Accept_Cnt
);

  imm_ent_t         w_dec;
  imm_ent_t         r_ent [2];
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_acc;
  logic             w_push;
  logic             w_pop;

  imm_ext_decode u_dec (
    .i_instr (Instr_In),
    .o_ent   (w_dec)
  );

  assign In_Ready   = (r_count != 2'(DEPTH));
  assign Out_Valid  = (r_count != 2'd0);
  assign w_push     = In_Valid & In_Ready;
  assign w_pop      = Out_Valid & Out_Ready;
  assign Imm_Out    = r_ent[0].imm;
  assign Imm_Kind   = r_ent[0].kind;
  assign Accept_Cnt = r_acc;

  // Entry 0 is always the head, so an emptied FIFO keeps presenting the last value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count  <= 2'd0;
      r_ent[0] <= '0;
      r_ent[1] <= '0;
      r_acc    <= '0;
    end else if (Flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_acc <= r_acc + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_ent[0] <= w_dec;
          end else begin
            r_ent[1] <= w_dec;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_ent[0] <= r_ent[1];
          end
          r_count <= r_count - 2'd1;
        end
        // Simultaneous push/pop only happens at count 1: replace the head in place.
        2'b11: r_ent[0] <= w_dec;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_ctrl.sv
// Randomized and directed bench for imm_extend_ctrl against a queue-based reference model.
module tb_imm_extend_ctrl;

  localparam int TB_CNT_W = 4;

  logic                Clk = 1'b0;
  logic                Rst_n = 1'b1;
  logic [31:0]         Instr_In = '0;
  logic                In_Valid = 1'b0;
  logic                In_Ready;
  logic                Flush = 1'b0;
  logic [31:0]         Imm_Out;
  logic [2:0]          Imm_Kind;
  logic                Out_Valid;
  logic                Out_Ready = 1'b0;
  logic [TB_CNT_W-1:0] Accept_Cnt;

  imm_extend_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Instr_In   (Instr_In),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Flush      (Flush),
    .Imm_Out    (Imm_Out),
    .Imm_Kind   (Imm_Kind),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Accept_Cnt (Accept_Cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  kind;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t held;
  int     acc;
  int     total = 0;
  int     bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] ins, output logic [31:0] imm,
                                  output logic [2:0] kind);
    int op;
    int s;
    op = int'(ins[31:26]);
    s  = int'($signed(ins[15:0]));
    if (op inside {[8:11], 32, 33, 35, 36, 37, 40, 41, 43}) begin
      imm = 32'(s); kind = 3'd1;
    end else if (op inside {[12:14]}) begin
      imm = 32'(ins[15:0]); kind = 3'd2;
    end else if (op == 15) begin
      imm = 32'(ins[15:0]) * 32'd65536; kind = 3'd3;
    end else if (op inside {1, [4:7]}) begin
      imm = 32'(s * 4); kind = 3'd4;
    end else if (op inside {2, 3}) begin
      imm = 32'(ins[25:0]) * 32'd4; kind = 3'd5;
    end else begin
      imm = 32'h0; kind = 3'd0;
    end
  endfunction

  task automatic check_model();
    m_ent_t h;
    h = (mq.size() != 0) ? mq[0] : held;
    chk("out_valid", 32'(Out_Valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(In_Ready), 32'(mq.size() < 2));
    chk("imm_out", Imm_Out, h.imm);
    chk("imm_kind", 32'(Imm_Kind), 32'(h.kind));
    chk("accept_cnt", 32'(Accept_Cnt), 32'(acc));
  endtask

  // One clock: drive inputs, advance the model with pre-edge occupancy, check after the edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    m_ent_t e;
    bit     push;
    bit     pop;
    In_Valid  = v;
    Instr_In  = ins;
    Out_Ready = ordy;
    Flush     = fl;
    push = v && (mq.size() < 2);
    pop  = ordy && (mq.size() > 0);
    @(posedge Clk);
    if (fl) begin
      if (mq.size() != 0) held = mq[0];
      mq.delete();
    end else begin
      if (pop) held = mq.pop_front();
      if (push) begin
        ref_dec(ins, e.imm, e.kind);
        mq.push_back(e);
        acc = (acc + 1) % (1 << TB_CNT_W);
      end
    end
    #1 check_model();
  endtask

  task automatic do_reset();
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    Flush     = 1'b0;
    Rst_n     = 1'b0;
    mq.delete();
    held.imm  = '0;
    held.kind = '0;
    acc       = 0;
    #1 check_model();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1 check_model();
  endtask

  logic [31:0] s1_in  [6] = '{32'h2008FFFF, 32'h3508FFFF, 32'h3C011234,
                              32'h1000FFFE, 32'h08000010, 32'h012A4020};
  logic [31:0] s1_imm [6] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000,
                              32'hFFFFFFF8, 32'h00000040, 32'h00000000};
  logic [2:0]  s1_kind[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  initial begin
    #2;
    do_reset();
    chk("rst_in_ready", 32'(In_Ready), 32'd1);
    chk("rst_imm", Imm_Out, 32'h0);

    // Decode sweep
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, s1_in[i], 1'b1, 1'b0);
      chk("s1_imm", Imm_Out, s1_imm[i]);
      chk("s1_kind", 32'(Imm_Kind), 32'(s1_kind[i]));
      chk("s1_valid", 32'(Out_Valid), 32'd1);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure
    do_reset();
    cyc(1'b1, 32'h20080005, 1'b0, 1'b0);
    cyc(1'b1, 32'h20080006, 1'b0, 1'b0);
    chk("s2_full_rdy", 32'(In_Ready), 32'd0);
    cyc(1'b1, 32'h20080007, 1'b0, 1'b0);
    chk("s2_head5", Imm_Out, 32'd5);
    chk("s2_held_cnt", 32'(Accept_Cnt), 32'd2);
    cyc(1'b1, 32'h20080007, 1'b1, 1'b0);
    chk("s2_head6", Imm_Out, 32'd6);
    cyc(1'b1, 32'h20080007, 1'b1, 1'b0);
    chk("s2_head7", Imm_Out, 32'd7);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s2_cnt", 32'(Accept_Cnt), 32'd3);
    chk("s2_empty", 32'(Out_Valid), 32'd0);

    // Streaming at count 1
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, {6'h08, 10'h0, 16'($urandom)}, 1'b1, 1'b0);
      chk("s3_valid", 32'(Out_Valid), 32'd1);
      chk("s3_ready", 32'(In_Ready), 32'd1);
    end
    chk("s3_cnt", 32'(Accept_Cnt), 32'd10);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush at full with concurrent push
    do_reset();
    cyc(1'b1, 32'h20080011, 1'b0, 1'b0);
    cyc(1'b1, 32'h20080012, 1'b0, 1'b0);
    cyc(1'b1, 32'h3C01ABCD, 1'b1, 1'b1);
    chk("s4_valid", 32'(Out_Valid), 32'd0);
    chk("s4_ready", 32'(In_Ready), 32'd1);
    chk("s4_cnt", 32'(Accept_Cnt), 32'd2);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s4_no_lui", 32'(Out_Valid), 32'd0);

    // Asynchronous reset with count 2
    cyc(1'b1, 32'h20080021, 1'b0, 1'b0);
    cyc(1'b1, 32'h20080022, 1'b0, 1'b0);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("s5_valid", 32'(Out_Valid), 32'd0);
    chk("s5_imm", Imm_Out, 32'h0);
    chk("s5_cnt", 32'(Accept_Cnt), 32'd0);
    do_reset();
    cyc(1'b1, 32'h2008FFFF, 1'b1, 1'b0);
    chk("s5_post_imm", Imm_Out, 32'hFFFFFFFF);
    chk("s5_post_kind", 32'(Imm_Kind), 32'd1);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
    chk("s6_wrap", 32'(Accept_Cnt), 32'd1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
